// File: rtl/subleq_ram_dp_if.sv
// Bus bundle for the Subleq dual-port RAM: sweep control, port A (read/write) and port B (fetch).
interface subleq_ram_dp_if #(
  parameter int P_ADDR = 8,
  parameter int P_DATA = 8
);
  logic              clr;
  logic              busy;
  logic              err;

  logic              a_en;
  logic              a_we;
  logic [P_ADDR-1:0] a_addr;
  logic [P_DATA-1:0] a_din;
  logic [P_DATA-1:0] a_dout;
  logic              a_vld;

  logic              b_en;
  logic [P_ADDR-1:0] b_addr;
  logic [P_DATA-1:0] b_dout;
  logic              b_vld;

  modport master (
    output clr, a_en, a_we, a_addr, a_din, b_en, b_addr,
    input  busy, err, a_dout, a_vld, b_dout, b_vld
  );

  modport slave (
    input  clr, a_en, a_we, a_addr, a_din, b_en, b_addr,
    output busy, err, a_dout, a_vld, b_dout, b_vld
  );
endinterface

// File: rtl/subleq_ram_dp.sv
// Dual-port synchronous RAM for the Subleq core with a built-in zero-fill sweep
// that runs after reset and on clr; both ports are blocked while it runs.
module subleq_ram_dp #(
  parameter int P_ADDR = 8,
  parameter int P_DATA = 8,
  parameter int P_MEM  = 256
) (
  input logic             clk,
  input logic             rst_n,
  subleq_ram_dp_if.slave  bus
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam int              IDX_W    = (P_MEM > 1) ? $clog2(P_MEM) : 1;
  localparam logic [P_ADDR:0] MEM_LIM  = (P_ADDR+1)'(P_MEM);
  localparam logic [P_ADDR-1:0] CNT_LAST = P_ADDR'(P_MEM - 1);

  state_t              state_q, state_d;
  logic [P_ADDR-1:0]   cnt_q, cnt_d;
  logic [P_DATA-1:0]   a_dout_q, a_dout_d;
  logic [P_DATA-1:0]   b_dout_q, b_dout_d;
  logic                a_vld_q, a_vld_d;
  logic                b_vld_q, b_vld_d;
  logic                err_q, err_d;

  logic [P_DATA-1:0]   mem_q [P_MEM];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [P_DATA-1:0]   mem_wdata;

  logic                a_ok, b_ok;
  logic [IDX_W-1:0]    a_idx, b_idx;

  // Indices are truncated to the array size; they are only used when in range.
  assign a_ok  = {1'b0, bus.a_addr} < MEM_LIM;
  assign b_ok  = {1'b0, bus.b_addr} < MEM_LIM;
  assign a_idx = bus.a_addr[IDX_W-1:0];
  assign b_idx = bus.b_addr[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_dout_d  = a_dout_q;
    b_dout_d  = b_dout_q;
    a_vld_d   = 1'b0;
    b_vld_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q[IDX_W-1:0];
    mem_wdata = '0;

    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      READY: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          // Reads sample the array before this edge's write lands: read-before-write.
          if (bus.a_en) begin
            if (bus.a_we) begin
              if (a_ok) begin
                mem_we    = 1'b1;
                mem_waddr = a_idx;
                mem_wdata = bus.a_din;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              a_vld_d  = 1'b1;
              a_dout_d = a_ok ? mem_q[a_idx] : '0;
              if (!a_ok) err_d = 1'b1;
            end
          end
          if (bus.b_en) begin
            b_vld_d  = 1'b1;
            b_dout_d = b_ok ? mem_q[b_idx] : '0;
            if (!b_ok) err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      a_dout_q <= '0;
      b_dout_q <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      err_q    <= err_d;
    end
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.busy   = (state_q == CLEAR);
  assign bus.err    = err_q;
  assign bus.a_dout = a_dout_q;
  assign bus.a_vld  = a_vld_q;
  assign bus.b_dout = b_dout_q;
  assign bus.b_vld  = b_vld_q;

endmodule

// File: doc/subleq_ram_dp.md
# subleq_ram_dp

Parametrised dual-port synchronous RAM for the Subleq core. Port A is read/write for operand load and store. Port B is read-only for instruction fetch. After every reset, and on request, a built-in sweep state machine zero-fills the whole array; both ports are blocked while the sweep runs.

## Interface
- P_ADDR, 8, address width of both ports
- P_DATA, 8, data word width
- P_MEM, 256, number of cells; must satisfy 1 <= P_MEM <= 2**P_ADDR
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  request a zero-fill sweep; sampled in READY only
- busy  output  1  high while sweeping; ports ignore requests
- a_en  input  1  port A request strobe
- a_we  input  1  port A: 1 = write, 0 = read
- a_addr  input  P_ADDR  port A address
- a_din  input  P_DATA  port A write data
- a_dout  output  P_DATA  port A read data; holds the last read value
- a_vld  output  1  one-cycle pulse when a_dout updates
- b_en  input  1  port B read strobe
- b_addr  input  P_ADDR  port B address
- b_dout  output  P_DATA  port B read data; holds the last read value
- b_vld  output  1  one-cycle pulse when b_dout updates
- err  output  1  one-cycle pulse when an accepted access has an out-of-range address (>= P_MEM)

## Operation
- States: CLEAR and READY. busy = (state == CLEAR).
- While rst_n is low:
  - state = CLEAR, sweep counter cnt = 0.
  - a_dout = b_dout = 0; a_vld = b_vld = err = 0.
  - Storage is not reset; the sweep zeroes it.
- CLEAR, each rising edge:
  - storage[cnt] <= 0, then cnt <= cnt + 1.
  - When cnt == P_MEM-1: state <= READY and cnt <= 0. cnt is P_ADDR bits wide, so wrap when P_MEM == 2**P_ADDR is legal.
  - a_en, b_en and clr are ignored.
  - a_vld, b_vld and err stay 0; a_dout and b_dout keep their values.
- READY with clr = 1 at an edge:
  - state <= CLEAR, cnt <= 0.
  - Port requests in that same cycle are dropped; no write, no vld, no err.
- READY with clr = 0, port A:
  - a_en && a_we && a_addr < P_MEM: storage[a_addr] <= a_din. No a_vld.
  - a_en && !a_we && a_addr < P_MEM: a_dout <= storage[a_addr], a_vld <= 1.
- READY with clr = 0, port B:
  - b_en && b_addr < P_MEM: b_dout <= storage[b_addr], b_vld <= 1.
- Out of range (addr >= P_MEM) on an accepted request:
  - A write: dropped, err <= 1.
  - A read: a_dout <= 0, a_vld <= 1, err <= 1.
  - B read: b_dout <= 0, b_vld <= 1, err <= 1.
  - If both ports fault in the same cycle, a single err pulse is produced.
- Collision, A write and B read to the same address in the same cycle: B returns the old contents (read-before-write); the write completes.
- Port A and port B reads to the same address in the same cycle both return the same value.
- Reset asserted mid-sweep: the sweep aborts and restarts from cell 0 after rst_n releases.
- Reset asserted mid-access: the access is lost; outputs go to their reset values immediately.

## Timing
- Read latency is 1 cycle: a request accepted at edge N gives dout/vld valid after edge N; vld drops after edge N+1 unless a new read is accepted.
- Back-to-back reads on every cycle are allowed on both ports at full rate; vld stays high.
- Write latency is 1 cycle: the data is readable by a request presented on the cycle after the write edge.
- Sweep length is exactly P_MEM edges. busy falls after the P_MEM-th edge following rst_n release or following the clr edge.
- The first accepted request is the one presented on the cycle in which busy is already low.
- busy, a_vld, b_vld and err are registered outputs; there is no combinational path from inputs to outputs.

## Test plan
- Parameters 4/8/12, reset release, all ports idle:
  - busy is high for exactly 12 edges, then low.
  - After that, a read of each address 0..11 on both ports returns 0 with vld pulsed.
- Write addr i with data 0xA0+i for i = 0..11 through A, then read all cells back-to-back through B:
  - b_dout sequence is 0xA0..0xAB, one per cycle.
  - b_vld stays high throughout.
  - err never pulses.
- Same-cycle A write of 0x55 to addr 3 (old value 0xA3) and B read of addr 3:
  - b_dout = 0xA3.
  - A B read of addr 3 on the next cycle gives 0x55.
- A read of addr 13 and A write to addr 14 (P_MEM = 12):
  - The read gives a_dout = 0, a_vld = 1, err = 1.
  - The write raises err, and the storage read back over addrs 0..11 is unchanged.
- Pulse clr with cells non-zero, and drive a_en write during the sweep:
  - busy is high for 12 edges.
  - The write is dropped; all cells read back 0 afterwards.
- Assert rst_n low at sweep cell 5, release after 2 cycles:
  - Outputs are 0 during reset.
  - busy then stays high for a full 12 edges.
  - All cells read back 0.
